// File: rtl/fetch_queue_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_stage_if
// Purpose  : Redirect, instruction-memory and decode handshake bundle for the
//            fetch queue stage. master = fetch stage, slave = environment.
// Revision : 1.0
// ============================================================================
interface fetch_queue_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              br_taken;
  logic              j_taken;
  logic              jr_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] jr_target;
  logic              irq;
  logic              exc;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;

  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc_plus4;

  logic              redirect_err;

  modport master (
    input  br_taken, j_taken, jr_taken, br_target, j_target, jr_target,
    input  irq, exc, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instr, id_pc_plus4, redirect_err
  );

  modport slave (
    output br_taken, j_taken, jr_taken, br_target, j_target, jr_target,
    output irq, exc, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc_plus4, redirect_err
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_stage
// Purpose  : Instruction fetch with credit-counted request/response memory port
//            and an FQ_DEPTH-entry queue toward decode. Optional macro
//            FETCH_KERNEL_BIT_EN preserves/forces the PC top bit on increment.
// Revision : 1.0
// ============================================================================
module fetch_queue_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 FQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [ADDR_W-1:0]  IRQ_VEC  = 32'h8000_0004,
  parameter logic [ADDR_W-1:0]  EXC_VEC  = 32'h8000_0008,
  parameter logic [ADDR_W-1:0]  ERR_VEC  = '1
) (
  input  logic                clk,
  input  logic                rst,
  fetch_queue_stage_if.master fq
);

  localparam int              PTR_W   = $clog2(FQ_DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc4_q, req_pc4_d;
  logic              inflight_q, inflight_d;
  logic              drop_q, drop_d;
  logic              redirect_err_q, redirect_err_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] instr_mem_q [FQ_DEPTH];
  logic [ADDR_W-1:0] pc4_mem_q   [FQ_DEPTH];

  logic              redirect;
  logic              sel_multi;
  logic [1:0]        sel_cnt;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_plus4;
  logic [CNT_W-1:0]  credits;
  logic              issue;
  logic              push;
  logic              pop;
  logic              head_valid;

  always_comb begin
    sel_cnt   = {1'b0, fq.br_taken} + {1'b0, fq.j_taken} + {1'b0, fq.jr_taken};
    sel_multi = !fq.irq && !fq.exc && (sel_cnt >= 2'd2);
    redirect  = fq.irq || fq.exc || (sel_cnt != 2'd0);
    if (fq.irq)           target = IRQ_VEC;
    else if (fq.exc)      target = EXC_VEC;
    else if (sel_multi)   target = ERR_VEC;
    else if (fq.br_taken) target = fq.br_target;
    else if (fq.j_taken)  target = fq.j_target;
    else                  target = fq.jr_target;
  end

  always_comb begin
`ifdef FETCH_KERNEL_BIT_EN
    pc_plus4 = {pc_q[ADDR_W-1] | fq.irq | fq.exc, pc_q[ADDR_W-2:0] + (ADDR_W-1)'(4)};
`else
    pc_plus4 = pc_q + ADDR_W'(4);
`endif
  end

  // Credits cover both stored entries and the response still on the bus,
  // so a push can never find the queue full.
  always_comb begin
    head_valid = (count_q != '0);
    credits    = count_q + CNT_W'(inflight_q);
    issue      = !rst && !redirect && (credits < DEPTH_C);
    push       = inflight_q && !drop_q && !redirect;
    pop        = head_valid && fq.id_ready && !redirect;
  end

  always_comb begin
    pc_d           = pc_q;
    req_pc4_d      = req_pc4_q;
    inflight_d     = issue;
    drop_d         = redirect && inflight_q;
    redirect_err_d = sel_multi;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    if (redirect) begin
      pc_d     = target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d      = pc_plus4;
        req_pc4_d = pc_plus4;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      req_pc4_q      <= '0;
      inflight_q     <= 1'b0;
      drop_q         <= 1'b0;
      redirect_err_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      pc_q           <= pc_d;
      req_pc4_q      <= req_pc4_d;
      inflight_q     <= inflight_d;
      drop_q         <= drop_d;
      redirect_err_q <= redirect_err_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= fq.imem_rdata;
      pc4_mem_q[wr_ptr_q]   <= req_pc4_q;
    end
  end

  assign fq.imem_req     = issue;
  assign fq.imem_addr    = pc_q;
  assign fq.id_valid     = head_valid;
  assign fq.id_instr     = head_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign fq.id_pc_plus4  = head_valid ? pc4_mem_q[rd_ptr_q] : '0;
  assign fq.redirect_err = redirect_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for fetch_queue_stage: transaction-level queue model
// compared every cycle, plus hand-computed literal expectations.
module tb_fetch_queue_stage;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] ins;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   chk_en;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_infl_pc;
  bit          m_err;
  logic [31:0] last_addr;

  fetch_queue_stage_if #(.ADDR_W(32), .DATA_W(32)) fq ();

  fetch_queue_stage #(.ADDR_W(32), .DATA_W(32), .FQ_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inc4(input logic [31:0] a);
`ifdef FETCH_KERNEL_BIT_EN
    return {a[31], a[30:0] + 31'd4};
`else
    return a + 32'd4;
`endif
  endfunction

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic bit m_redirect();
    return fq.irq || fq.exc || fq.br_taken || fq.j_taken || fq.jr_taken;
  endfunction

  function automatic bit m_multi();
    return !fq.irq && !fq.exc &&
           ((int'(fq.br_taken) + int'(fq.j_taken) + int'(fq.jr_taken)) > 1);
  endfunction

  function automatic logic [31:0] m_target();
    if (fq.irq)      return 32'h8000_0004;
    if (fq.exc)      return 32'h8000_0008;
    if (m_multi())   return 32'hFFFF_FFFF;
    if (fq.br_taken) return fq.br_target;
    if (fq.j_taken)  return fq.j_target;
    return fq.jr_target;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc      = 32'h0;
    m_infl    = 1'b0;
    m_infl_pc = 32'h0;
    m_err     = 1'b0;
  endtask

  // One clock of the fetch contract, evaluated with the inputs of the ending cycle.
  task automatic model_step();
    bit req;
    if (rst) begin
      model_reset();
    end else if (m_redirect()) begin
      m_q.delete();
      m_pc   = m_target();
      m_err  = m_multi();
      m_infl = 1'b0;
    end else begin
      req = (m_q.size() + int'(m_infl)) < DEPTH;
      if (m_q.size() > 0 && fq.id_ready) void'(m_q.pop_front());
      if (m_infl) m_q.push_back('{pc4: inc4(m_infl_pc), ins: imem_f(m_infl_pc)});
      m_err = 1'b0;
      if (req) begin
        m_infl    = 1'b1;
        m_infl_pc = m_pc;
        m_pc      = inc4(m_pc);
      end else begin
        m_infl = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    bit exp_req;
    last_addr = fq.imem_addr;
    if (chk_en) begin
      exp_req = !rst && !m_redirect() && ((m_q.size() + int'(m_infl)) < DEPTH);
      chk("imem_req", 32'(fq.imem_req), 32'(exp_req));
      chk("imem_addr", fq.imem_addr, m_pc);
      chk("id_valid", 32'(fq.id_valid), 32'(m_q.size() != 0));
      chk("id_instr", fq.id_instr, (m_q.size() != 0) ? m_q[0].ins : 32'h0);
      chk("id_pc_plus4", fq.id_pc_plus4, (m_q.size() != 0) ? m_q[0].pc4 : 32'h0);
      chk("redirect_err", 32'(fq.redirect_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    fq.imem_rdata = imem_f(last_addr);
  endtask

  task automatic mid();
    #5;
  endtask

  task automatic clr_redir();
    fq.br_taken = 1'b0; fq.j_taken = 1'b0; fq.jr_taken = 1'b0;
    fq.irq      = 1'b0; fq.exc     = 1'b0;
  endtask

  initial begin
    int nreq;
    logic [31:0] wrap_exp;
    checks = 0; errors = 0; chk_en = 1'b0;
    rst = 1'b0;
    clr_redir();
    fq.br_target = 32'h0; fq.j_target = 32'h0; fq.jr_target = 32'h0;
    fq.id_ready = 1'b1; fq.imem_rdata = 32'h0;
    last_addr = 32'h0;
    #1 rst = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // Reset state
    tick(); mid();
    chk("L_rst_req", 32'(fq.imem_req), 32'h0);
    chk("L_rst_valid", 32'(fq.id_valid), 32'h0);
    chk("L_rst_err", 32'(fq.redirect_err), 32'h0);
    tick(); rst = 1'b0;

    // Free-run from reset: cycle k fetches 4k, decode sees pc+4 from cycle 2
    mid();
    chk("L_run_addr0", fq.imem_addr, 32'h0);
    chk("L_run_req0", 32'(fq.imem_req), 32'h1);
    for (int k = 1; k < 8; k++) begin
      tick(); mid();
      chk("L_run_addr", fq.imem_addr, 32'(4 * k));
      if (k >= 2) begin
        chk("L_run_pc4", fq.id_pc_plus4, 32'(4 * (k - 1)));
        chk("L_run_instr", fq.id_instr, imem_f(32'(4 * (k - 2))));
      end
    end

    // Branch with a request in flight
    tick(); fq.br_taken = 1'b1; fq.br_target = 32'h100;
    mid(); chk("L_br_req", 32'(fq.imem_req), 32'h0);
    tick(); clr_redir();
    mid();
    chk("L_br_valid1", 32'(fq.id_valid), 32'h0);
    chk("L_br_addr", fq.imem_addr, 32'h100);
    tick(); mid(); chk("L_br_valid2", 32'(fq.id_valid), 32'h0);
    tick(); mid();
    chk("L_br_valid3", 32'(fq.id_valid), 32'h1);
    chk("L_br_pc4", fq.id_pc_plus4, 32'h104);

    // Interrupt beats branch; exception alone; both interrupt and exception
    tick(); fq.irq = 1'b1; fq.br_taken = 1'b1;
    tick(); clr_redir(); mid(); chk("L_irq_addr", fq.imem_addr, 32'h8000_0004);
    tick(); fq.exc = 1'b1;
    tick(); clr_redir(); mid(); chk("L_exc_addr", fq.imem_addr, 32'h8000_0008);
    tick(); fq.irq = 1'b1; fq.exc = 1'b1;
    tick(); clr_redir(); mid(); chk("L_irqexc_addr", fq.imem_addr, 32'h8000_0004);

    // Non-one-hot selects
    tick(); fq.j_taken = 1'b1; fq.jr_taken = 1'b1;
    fq.j_target = 32'h40; fq.jr_target = 32'h80;
    tick(); clr_redir(); mid();
    chk("L_err_addr", fq.imem_addr, 32'hFFFF_FFFF);
    chk("L_err_pulse", 32'(fq.redirect_err), 32'h1);
    tick(); mid(); chk("L_err_clear", 32'(fq.redirect_err), 32'h0);

    // Decode stall after a redirect to 0x200
    tick(); fq.jr_taken = 1'b1; fq.jr_target = 32'h200; fq.id_ready = 1'b0;
    tick(); clr_redir();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (fq.imem_req) nreq++;
      tick();
    end
    chk("L_stall_reqs", 32'(nreq), 32'd4);
    fq.id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("L_drain_pc4", fq.id_pc_plus4, 32'h204 + 32'(4 * k));
      chk("L_drain_instr", fq.id_instr, imem_f(32'h200 + 32'(4 * k)));
      tick();
    end

    // PC wrap across bit 31
    fq.j_taken = 1'b1; fq.j_target = 32'h7FFF_FFFC;
    tick(); clr_redir(); mid();
    chk("L_wrap_addr0", fq.imem_addr, 32'h7FFF_FFFC);
    chk("L_wrap_req", 32'(fq.imem_req), 32'h1);
`ifdef FETCH_KERNEL_BIT_EN
    wrap_exp = 32'h0000_0000;
`else
    wrap_exp = 32'h8000_0000;
`endif
    tick(); mid(); chk("L_wrap_addr1", fq.imem_addr, wrap_exp);

    // Asynchronous reset mid-operation
    tick(); tick();
    rst = 1'b1; model_reset();
    mid();
    chk("L_arst_req", 32'(fq.imem_req), 32'h0);
    chk("L_arst_valid", 32'(fq.id_valid), 32'h0);
    chk("L_arst_addr", fq.imem_addr, 32'h0);
    tick(); tick(); rst = 1'b0;
    mid(); chk("L_rel_addr", fq.imem_addr, 32'h0);
    tick(); tick(); mid(); chk("L_rel_pc4", fq.id_pc_plus4, 32'h4);
    tick(); tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
